// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - serial 8N1 boot loader that writes a framed image into word memory
module boot_loader #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int AW           = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rxd,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_mask,
    output logic          halt_n,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {
        SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA_H, DATA_L, CSUM, DONE
    } fr_state_t;

    logic            rxd_s1_q, rxd_s2_q, rxd_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            byte_valid, frame_err;

    fr_state_t       fr_state_q, fr_state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      addr_hi_q, addr_hi_d;
    logic [15:0]     len_q, len_d;
    logic [7:0]      hi_q, hi_d;
    logic [7:0]      csum_q, csum_d;
    logic [15:0]     din_q, din_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [4:0]      done_cnt_q, done_cnt_d;

    // Receiver: start edge, half-bit confirm, then whole-bit sampling up to the stop bit
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rxd_prev_q && !rxd_s2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    byte_valid = rxd_s2_q;
                    frame_err  = !rxd_s2_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Frame parser; the address bump after a write is independent of byte arrival
    always_comb begin
        fr_state_d = fr_state_q;
        addr_d     = we_q ? addr_q + AW'(1) : addr_q;
        addr_hi_d  = addr_hi_q;
        len_d      = len_q;
        hi_d       = hi_q;
        csum_d     = csum_q;
        din_d      = din_q;
        we_d       = 1'b0;
        err_d      = err_q;
        done_cnt_d = done_cnt_q;
        if (fr_state_q == DONE && done_cnt_q != 5'd16) done_cnt_d = done_cnt_q + 5'd1;
        if (frame_err && fr_state_q != DONE) begin
            err_d      = 1'b1;
            fr_state_d = SYNC;
        end else if (byte_valid) begin
            case (fr_state_q)
                SYNC: begin
                    if (rx_shift_q == 8'hA5) begin
                        fr_state_d = ADDR_H;
                        csum_d     = 8'h00;
                        err_d      = 1'b0;
                    end
                end
                ADDR_H: begin
                    addr_hi_d  = rx_shift_q;
                    fr_state_d = ADDR_L;
                end
                ADDR_L: begin
                    addr_d     = AW'({addr_hi_q, rx_shift_q});
                    fr_state_d = LEN_H;
                end
                LEN_H: begin
                    len_d      = {rx_shift_q, len_q[7:0]};
                    fr_state_d = LEN_L;
                end
                LEN_L: begin
                    len_d      = {len_q[15:8], rx_shift_q};
                    fr_state_d = ({len_q[15:8], rx_shift_q} == 16'h0000) ? CSUM : DATA_H;
                end
                DATA_H: begin
                    hi_d       = rx_shift_q;
                    csum_d     = csum_q ^ rx_shift_q;
                    fr_state_d = DATA_L;
                end
                DATA_L: begin
                    din_d      = {hi_q, rx_shift_q};
                    we_d       = 1'b1;
                    csum_d     = csum_q ^ rx_shift_q;
                    len_d      = len_q - 16'd1;
                    fr_state_d = (len_q == 16'd1) ? CSUM : DATA_H;
                end
                CSUM: begin
                    if (rx_shift_q == csum_q) begin
                        fr_state_d = DONE;
                    end else begin
                        err_d      = 1'b1;
                        fr_state_d = SYNC;
                    end
                end
                DONE:    fr_state_d = DONE;
                default: fr_state_d = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            fr_state_q <= SYNC;
            addr_q     <= '0;
            addr_hi_q  <= 8'h00;
            len_q      <= 16'h0000;
            hi_q       <= 8'h00;
            csum_q     <= 8'h00;
            din_q      <= 16'h0000;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            done_cnt_q <= 5'd0;
        end else begin
            rxd_s1_q   <= rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            fr_state_q <= fr_state_d;
            addr_q     <= addr_d;
            addr_hi_q  <= addr_hi_d;
            len_q      <= len_d;
            hi_q       <= hi_d;
            csum_q     <= csum_d;
            din_q      <= din_d;
            we_q       <= we_d;
            err_q      <= err_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_din   = din_q;
    assign mem_mask  = {2{we_q}};
    assign halt_n    = (fr_state_q == DONE);
    assign cpu_rst_n = (done_cnt_q == 5'd16);
    assign busy      = (fr_state_q != SYNC) && (fr_state_q != DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - table-driven, directed and randomized checks of boot_loader
module tb_boot_loader;

    localparam int CPB = 4;
    localparam int AW  = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rxd = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [1:0]    mem_mask;
    logic          halt_n, cpu_rst_n, busy, err;

    boot_loader #(.CLKS_PER_BIT(CPB), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_mask(mem_mask),
        .halt_n(halt_n), .cpu_rst_n(cpu_rst_n), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Write capture and pulse/lane monitor
    logic [14:0] got_a[$];
    logic [15:0] got_d[$];
    int  cyc = 0, halt_rise = -1, cpu_rise = -1;
    logic prev_we = 1'b0, halt_prev = 1'b0, cpu_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_we = 1'b0; halt_prev = 1'b0; cpu_prev = 1'b0;
            halt_rise = -1; cpu_rise = -1;
        end else begin
            if (mem_we) begin
                got_a.push_back(mem_addr);
                got_d.push_back(mem_din);
                chk("mem_mask", 32'(mem_mask), 32'd3);
                chk("we_single_cycle", 32'(prev_we), 32'd0);
            end
            if (halt_n && !halt_prev) halt_rise = cyc;
            if (cpu_rst_n && !cpu_prev) cpu_rise = cyc;
            prev_we = mem_we; halt_prev = halt_n; cpu_prev = cpu_rst_n;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: parse a whole byte stream by index arithmetic
    logic [7:0]  in_bytes[$];
    logic [14:0] exp_a[$];
    logic [15:0] exp_d[$];
    logic        m_err, m_halt;

    task automatic model_run();
        int i, n, len, a;
        logic [7:0] cs;
        exp_a.delete(); exp_d.delete();
        m_err = 1'b0; m_halt = 1'b0; i = 0; n = in_bytes.size();
        while (i < n && !m_halt) begin
            if (in_bytes[i] != 8'hA5) begin i++; continue; end
            if (i + 4 >= n) break;
            m_err = 1'b0;
            a   = int'({in_bytes[i+1], in_bytes[i+2]}) % (1 << AW);
            len = int'({in_bytes[i+3], in_bytes[i+4]});
            i += 5; cs = 8'h00;
            for (int w = 0; w < len && i + 1 < n; w++) begin
                exp_a.push_back(15'(a));
                exp_d.push_back({in_bytes[i], in_bytes[i+1]});
                cs ^= in_bytes[i] ^ in_bytes[i+1];
                a = (a + 1) % (1 << AW);
                i += 2;
            end
            if (i >= n) break;
            if (in_bytes[i] == cs) m_halt = 1'b1;
            else                   m_err  = 1'b1;
            i++;
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rxd = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin rxd = b[i]; tick(CPB); end
        rxd = stop_ok; tick(CPB);
        rxd = 1'b1; tick(2 * CPB);
    endtask

    task automatic send_stream();
        for (int i = 0; i < in_bytes.size(); i++) send_byte(in_bytes[i], 1'b1);
    endtask

    task automatic apply_reset();
        rxd = 1'b1;
        rst_n = 1'b0;
        tick(3);
        got_a.delete(); got_d.delete();
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic check_vs_model(input string nm);
        int m;
        chk({nm, "_nwrites_model"}, 32'(got_a.size()), 32'(exp_a.size()));
        m = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < m; i++) begin
            chk({nm, "_addr_model"}, 32'(got_a[i]), 32'(exp_a[i]));
            chk({nm, "_data_model"}, 32'(got_d[i]), 32'(exp_d[i]));
        end
        chk({nm, "_err_model"}, 32'(err), 32'(m_err));
        chk({nm, "_halt_model"}, 32'(halt_n), 32'(m_halt));
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        if (m_halt) chk({nm, "_cpu_rst_delay"}, 32'(cpu_rise - halt_rise), 32'd16);
        else        chk({nm, "_cpu_rst_low"}, 32'(cpu_rst_n), 32'd0);
    endtask

    typedef struct packed {
        logic [191:0] b;
        logic [7:0]   n;
        logic [7:0]   nw;
        logic         err;
        logic         halt;
        logic [14:0]  a0;
        logic [15:0]  d0;
        logic [14:0]  a1;
        logic [15:0]  d1;
    } vec_t;

    vec_t tbl[7];

    task automatic push_frame(input logic bad);
        logic [7:0] cs, x;
        int len;
        cs = 8'h00;
        len = $urandom_range(0, 3);
        in_bytes.push_back(8'hA5);
        in_bytes.push_back(8'($urandom));
        in_bytes.push_back(8'($urandom));
        in_bytes.push_back(8'h00);
        in_bytes.push_back(8'(len));
        for (int i = 0; i < 2 * len; i++) begin
            x = 8'($urandom);
            cs ^= x;
            in_bytes.push_back(x);
        end
        in_bytes.push_back(bad ? cs ^ 8'(1 + $urandom_range(0, 254)) : cs);
    endtask

    initial begin
        logic [7:0] jb;
        int k, last;
        logic bad;

        tbl[0] = '{b: 192'({8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08}),
                   n: 8'd10, nw: 8'd2, err: 1'b0, halt: 1'b1,
                   a0: 15'h0010, d0: 16'h1234, a1: 15'h0011, d1: 16'h5678};
        tbl[1] = '{b: 192'({8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09}),
                   n: 8'd10, nw: 8'd2, err: 1'b1, halt: 1'b0,
                   a0: 15'h0010, d0: 16'h1234, a1: 15'h0011, d1: 16'h5678};
        tbl[2] = '{b: 192'({8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09,
                            8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08}),
                   n: 8'd20, nw: 8'd4, err: 1'b0, halt: 1'b1,
                   a0: 15'h0010, d0: 16'h1234, a1: 15'h0011, d1: 16'h5678};
        tbl[3] = '{b: 192'({8'hA5, 8'h7F, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00}),
                   n: 8'd10, nw: 8'd2, err: 1'b0, halt: 1'b1,
                   a0: 15'h7FFF, d0: 16'hAABB, a1: 15'h0000, d1: 16'hCCDD};
        tbl[4] = '{b: 192'({8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}),
                   n: 8'd6, nw: 8'd0, err: 1'b0, halt: 1'b1,
                   a0: 15'h0, d0: 16'h0, a1: 15'h0, d1: 16'h0};
        tbl[5] = '{b: 192'({8'h11, 8'h22, 8'hA5, 8'h00, 8'h10, 8'h00, 8'h02,
                            8'h12, 8'h34, 8'h56, 8'h78, 8'h08}),
                   n: 8'd12, nw: 8'd2, err: 1'b0, halt: 1'b1,
                   a0: 15'h0010, d0: 16'h1234, a1: 15'h0011, d1: 16'h5678};
        tbl[6] = '{b: 192'({8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h00}),
                   n: 8'd8, nw: 8'd1, err: 1'b0, halt: 1'b1,
                   a0: 15'h0020, d0: 16'hA5A5, a1: 15'h0020, d1: 16'hA5A5};

        // Reset state
        rst_n = 1'b0;
        tick(2);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_din", 32'(mem_din), 32'd0);
        chk("rst_mem_mask", 32'(mem_mask), 32'd0);
        chk("rst_halt_n", 32'(halt_n), 32'd0);
        chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        for (int v = 0; v < 7; v++) begin
            apply_reset();
            in_bytes.delete();
            for (int i = 0; i < int'(tbl[v].n); i++)
                in_bytes.push_back(tbl[v].b[8 * (int'(tbl[v].n) - 1 - i) +: 8]);
            model_run();
            send_stream();
            tick(40);
            chk($sformatf("vec%0d_nwrites", v), 32'(got_a.size()), 32'(tbl[v].nw));
            chk($sformatf("vec%0d_err", v), 32'(err), 32'(tbl[v].err));
            chk($sformatf("vec%0d_halt_n", v), 32'(halt_n), 32'(tbl[v].halt));
            chk($sformatf("vec%0d_cpu_rst_n", v), 32'(cpu_rst_n), 32'(tbl[v].halt));
            if (tbl[v].nw != 0 && got_a.size() == int'(tbl[v].nw)) begin
                last = got_a.size() - 1;
                chk($sformatf("vec%0d_addr_first", v), 32'(got_a[0]), 32'(tbl[v].a0));
                chk($sformatf("vec%0d_data_first", v), 32'(got_d[0]), 32'(tbl[v].d0));
                chk($sformatf("vec%0d_addr_last", v), 32'(got_a[last]), 32'(tbl[v].a1));
                chk($sformatf("vec%0d_data_last", v), 32'(got_d[last]), 32'(tbl[v].d1));
            end
            check_vs_model($sformatf("vec%0d", v));
        end

        // Framing error with no frame in progress
        apply_reset();
        send_byte(8'h3C, 1'b0);
        tick(10);
        chk("frame_err_err", 32'(err), 32'd1);
        chk("frame_err_busy", 32'(busy), 32'd0);
        chk("frame_err_nwrites", 32'(got_a.size()), 32'd0);

        // Framing error mid-frame drops back to SYNC
        apply_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("midframe_busy", 32'(busy), 32'd1);
        send_byte(8'h10, 1'b0);
        tick(10);
        chk("midframe_ferr_err", 32'(err), 32'd1);
        chk("midframe_ferr_busy", 32'(busy), 32'd0);

        // One-clock glitch just ahead of a frame must not be taken as a start bit
        apply_reset();
        rxd = 1'b0; tick(1);
        rxd = 1'b1; tick(3);
        in_bytes.delete();
        for (int i = 0; i < 10; i++) in_bytes.push_back(tbl[0].b[8 * (9 - i) +: 8]);
        send_stream();
        tick(40);
        chk("glitch_nwrites", 32'(got_a.size()), 32'd2);
        chk("glitch_halt_n", 32'(halt_n), 32'd1);

        // Asynchronous reset mid-byte after a completed load
        apply_reset();
        in_bytes.delete();
        for (int i = 0; i < 6; i++) in_bytes.push_back(tbl[4].b[8 * (5 - i) +: 8]);
        send_stream();
        tick(30);
        chk("pre_async_halt_n", 32'(halt_n), 32'd1);
        chk("pre_async_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        rxd = 1'b0;
        tick(6);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_we", 32'(mem_we), 32'd0);
        chk("async_mem_addr", 32'(mem_addr), 32'd0);
        chk("async_mem_mask", 32'(mem_mask), 32'd0);
        chk("async_halt_n", 32'(halt_n), 32'd0);
        chk("async_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        rxd = 1'b1;

        // Randomized frames against the reference model
        for (int it = 0; it < 10; it++) begin
            apply_reset();
            in_bytes.delete();
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                do jb = 8'($urandom); while (jb == 8'hA5);
                in_bytes.push_back(jb);
            end
            bad = ($urandom_range(0, 2) == 0);
            push_frame(bad);
            if (bad) push_frame(1'b0);
            model_run();
            send_stream();
            tick(40);
            check_vs_model($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
